// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified-memory port
//               arbiter (FSM state encoding, requester IDs, latency
//               counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } arb_state_e;

    // Requester identifiers; also the bit index into the request vector.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    // Width of the read-latency counter (holds RD_LAT-1, RD_LAT <= 4).
    localparam int CNT_W = 2;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr2
// Description : Combinational 2-way round-robin picker. When both requests
//               are present the requester that was not granted last wins.
// Ports       : req[1:0]  - request vector, indexed by requester ID
//               last      - ID of the most recently granted requester
//               gnt_valid - at least one request present
//               gnt_id    - ID of the selected requester
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else begin
            // Single (or no) request: pick whichever one is present.
            gnt_id = req[REQ_LD];
        end
    end

endmodule : arb_rr2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the unified instruction/data memory between the CPU
//               and the program loader. 2-way round-robin arbitration; in
//               boot mode (ld_boot=1) only the loader can be granted.
//               One access in flight at a time: IDLE -> ISSUE -> [WAIT] ->
//               CAPT -> RESP for reads, IDLE -> ISSUE -> RESP for writes.
// Ports       : clk, reset (async, active-low)
//               cpu_req/we/adr/wd -> cpu_rdy (1-cycle pulse), cpu_rd
//               ld_req/we/adr/wd  -> ld_rdy  (1-cycle pulse), ld_rd
//               ld_boot           -  loader-exclusive mode
//               mem_en/we/adr/wd  -> memory macro, mem_rd <- memory macro
//               busy              -  arbiter not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic          cpu_rdy,
    output logic [DW-1:0] cpu_rd,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_adr,
    input  logic [DW-1:0] ld_wd,
    output logic          ld_rdy,
    output logic [DW-1:0] ld_rd,
    input  logic          ld_boot,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          busy
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);

    arb_state_e       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             gnt_q,     gnt_d;
    logic             last_q,    last_d;
    logic             mem_en_q,  mem_en_d;
    logic             mem_we_q,  mem_we_d;
    logic [AW-1:0]    mem_adr_q, mem_adr_d;
    logic [DW-1:0]    mem_wd_q,  mem_wd_d;
    logic [DW-1:0]    cpu_rd_q,  cpu_rd_d;
    logic [DW-1:0]    ld_rd_q,   ld_rd_d;

    logic [1:0]       w_elig;
    logic             w_gnt_valid;
    logic             w_gnt_id;

    // Boot mode removes the CPU from the eligible set; an already granted
    // CPU access is unaffected because the grant lives in gnt_q.
    assign w_elig[REQ_CPU] = cpu_req & ~ld_boot;
    assign w_elig[REQ_LD]  = ld_req;

    arb_rr2 u_arb_rr2 (
        .req       (w_elig),
        .last      (last_q),
        .gnt_valid (w_gnt_valid),
        .gnt_id    (w_gnt_id)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cpu_rd_d  = cpu_rd_q;
        ld_rd_d   = ld_rd_q;
        // The memory-side registers are loaded only on the IDLE->ISSUE
        // transition, so they read as zero in every state except ISSUE.
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        mem_adr_d = '0;
        mem_wd_d  = '0;

        case (state_q)
            IDLE: begin
                if (w_gnt_valid) begin
                    gnt_d    = w_gnt_id;
                    mem_en_d = 1'b1;
                    if (w_gnt_id == REQ_LD) begin
                        mem_we_d  = ld_we;
                        mem_adr_d = ld_adr;
                        mem_wd_d  = ld_wd;
                    end else begin
                        mem_we_d  = cpu_we;
                        mem_adr_d = cpu_adr;
                        mem_wd_d  = cpu_wd;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                last_d = gnt_q;
                if (mem_we_q) begin
                    state_d = RESP;
                end else if (RD_LAT == 1) begin
                    state_d = CAPT;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The counter reaches zero on the transition into CAPT,
                // giving RD_LAT-1 cycles in WAIT.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                if (gnt_q == REQ_LD) begin
                    ld_rd_d = mem_rd;
                end else begin
                    cpu_rd_d = mem_rd;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_q     <= REQ_CPU;
            last_q    <= REQ_LD;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            mem_wd_q  <= '0;
            cpu_rd_q  <= '0;
            ld_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            mem_adr_q <= mem_adr_d;
            mem_wd_q  <= mem_wd_d;
            cpu_rd_q  <= cpu_rd_d;
            ld_rd_q   <= ld_rd_d;
        end
    end

    assign mem_en  = mem_en_q;
    assign mem_we  = mem_we_q;
    assign mem_adr = mem_adr_q;
    assign mem_wd  = mem_wd_q;
    assign cpu_rd  = cpu_rd_q;
    assign ld_rd   = ld_rd_q;
    assign cpu_rdy = (state_q == RESP) && (gnt_q == REQ_CPU);
    assign ld_rdy  = (state_q == RESP) && (gnt_q == REQ_LD);
    assign busy    = (state_q != IDLE);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. Two
//               instances: RD_LAT=1 (dut1) and RD_LAT=3 (dut3). Request
//               lines are separate per instance; address/data are shared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam logic [31:0] GARBAGE = 32'hA5A5_A5A5;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_req3, cpu_we;
    logic [31:0] cpu_adr, cpu_wd;
    logic        ld_req, ld_req3, ld_we;
    logic [31:0] ld_adr, ld_wd;
    logic        ld_boot;
    logic [31:0] mem_rd1, mem_rd3;

    logic        cpu_rdy1, ld_rdy1, mem_en1, mem_we1, busy1;
    logic [31:0] cpu_rd1, ld_rd1, mem_adr1, mem_wd1;
    logic        cpu_rdy3, ld_rdy3, mem_en3, mem_we3, busy3;
    logic [31:0] cpu_rd3, ld_rd3, mem_adr3, mem_wd3;

    int n_chk = 0;
    int n_err = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rdy(cpu_rdy1), .cpu_rd(cpu_rd1),
        .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wd(ld_wd),
        .ld_rdy(ld_rdy1), .ld_rd(ld_rd1), .ld_boot(ld_boot),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_adr(mem_adr1), .mem_wd(mem_wd1),
        .mem_rd(mem_rd1), .busy(busy1)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req3), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rdy(cpu_rdy3), .cpu_rd(cpu_rd3),
        .ld_req(ld_req3), .ld_we(ld_we), .ld_adr(ld_adr), .ld_wd(ld_wd),
        .ld_rdy(ld_rdy3), .ld_rd(ld_rd3), .ld_boot(ld_boot),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_adr(mem_adr3), .mem_wd(mem_wd3),
        .mem_rd(mem_rd3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        cpu_req  = 1'b0; cpu_req3 = 1'b0; cpu_we = 1'b0;
        cpu_adr  = '0;   cpu_wd   = '0;
        ld_req   = 1'b0; ld_req3  = 1'b0; ld_we  = 1'b0;
        ld_adr   = '0;   ld_wd    = '0;
        ld_boot  = 1'b0;
        mem_rd1  = GARBAGE;
        mem_rd3  = GARBAGE;

        // ---- Reset state ------------------------------------------------
        step; step;
        chk1 ("rst_busy",    busy1,    1'b0);
        chk1 ("rst_mem_en",  mem_en1,  1'b0);
        chk1 ("rst_mem_we",  mem_we1,  1'b0);
        chk32("rst_mem_adr", mem_adr1, 32'h0);
        chk32("rst_mem_wd",  mem_wd1,  32'h0);
        chk1 ("rst_cpu_rdy", cpu_rdy1, 1'b0);
        chk1 ("rst_ld_rdy",  ld_rdy1,  1'b0);
        chk32("rst_cpu_rd",  cpu_rd1,  32'h0);
        chk32("rst_ld_rd",   ld_rd1,   32'h0);
        chk1 ("rst_busy3",   busy3,    1'b0);
        reset = 1'b1;
        step;

        // ---- CPU-only read, RD_LAT=1 -------------------------------------
        cpu_we = 1'b0; cpu_adr = 32'h10; cpu_req = 1'b1;          // cycle 0
        chk1 ("t1_c0_busy", busy1, 1'b0);
        step;                                                     // cycle 1
        chk1 ("t1_c1_mem_en",  mem_en1,  1'b1);
        chk32("t1_c1_mem_adr", mem_adr1, 32'h10);
        chk1 ("t1_c1_mem_we",  mem_we1,  1'b0);
        step; mem_rd1 = 32'hE3A0_1005;                            // cycle 2
        chk1 ("t1_c2_mem_en",  mem_en1,  1'b0);
        chk1 ("t1_c2_cpu_rdy", cpu_rdy1, 1'b0);
        step; mem_rd1 = GARBAGE;                                  // cycle 3
        chk1 ("t1_c3_cpu_rdy", cpu_rdy1, 1'b1);
        chk32("t1_c3_cpu_rd",  cpu_rd1,  32'hE3A0_1005);
        chk32("t1_c3_ld_rd",   ld_rd1,   32'h0);
        chk32("t1_c3_mem_adr", mem_adr1, 32'h0);
        cpu_req = 1'b0;
        step;                                                     // cycle 4
        chk1 ("t1_c4_cpu_rdy", cpu_rdy1, 1'b0);
        chk1 ("t1_c4_busy",    busy1,    1'b0);

        // ---- Loader-only write ------------------------------------------
        ld_we = 1'b1; ld_adr = 32'h4; ld_wd = 32'hDEAD_BEEF; ld_req = 1'b1;
        step;                                                     // cycle 1
        chk1 ("t2_c1_mem_en",  mem_en1,  1'b1);
        chk1 ("t2_c1_mem_we",  mem_we1,  1'b1);
        chk32("t2_c1_mem_adr", mem_adr1, 32'h4);
        chk32("t2_c1_mem_wd",  mem_wd1,  32'hDEAD_BEEF);
        step;                                                     // cycle 2
        chk1 ("t2_c2_ld_rdy",  ld_rdy1,  1'b1);
        chk1 ("t2_c2_cpu_rdy", cpu_rdy1, 1'b0);
        chk1 ("t2_c2_mem_en",  mem_en1,  1'b0);
        chk1 ("t2_c2_mem_we",  mem_we1,  1'b0);
        ld_req = 1'b0;
        step;
        chk1 ("t2_c3_ld_rdy",  ld_rdy1,  1'b0);
        chk32("t2_c3_ld_rd",   ld_rd1,   32'h0);
        chk32("t2_c3_cpu_rd",  cpu_rd1,  32'hE3A0_1005);

        // ---- Round robin, both requesting writes continuously -----------
        reset = 1'b0; step; reset = 1'b1;
        chk32("t3_rst_cpu_rd", cpu_rd1, 32'h0);
        cpu_we = 1'b1; cpu_adr = 32'h100; cpu_wd = 32'h1111_1111;
        ld_we  = 1'b1; ld_adr  = 32'h200; ld_wd  = 32'h2222_2222;
        cpu_req = 1'b1; ld_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp_cpu;
            exp_cpu = (i % 2 == 0);
            step;
            chk1 ("t3_mem_en",  mem_en1,  1'b1);
            chk32("t3_mem_adr", mem_adr1, exp_cpu ? 32'h100 : 32'h200);
            chk32("t3_mem_wd",  mem_wd1,  exp_cpu ? 32'h1111_1111 : 32'h2222_2222);
            step;
            chk1 ("t3_cpu_rdy", cpu_rdy1, exp_cpu);
            chk1 ("t3_ld_rdy",  ld_rdy1,  !exp_cpu);
            step;
            chk1 ("t3_idle_busy", busy1, 1'b0);
        end

        // ---- Boot mode: loader only, then CPU resumes -------------------
        ld_boot = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step;
            chk32("t4_boot_mem_adr", mem_adr1, 32'h200);
            step;
            chk1 ("t4_boot_ld_rdy",  ld_rdy1,  1'b1);
            chk1 ("t4_boot_cpu_rdy", cpu_rdy1, 1'b0);
            step;
        end
        ld_boot = 1'b0;
        step;
        chk32("t4_after_boot_mem_adr", mem_adr1, 32'h100);
        step;
        chk1 ("t4_after_boot_cpu_rdy", cpu_rdy1, 1'b1);
        cpu_req = 1'b0; ld_req = 1'b0;
        step;
        chk1 ("t4_idle_busy", busy1, 1'b0);

        // ---- RD_LAT=3 CPU read -------------------------------------------
        cpu_we = 1'b0; cpu_adr = 32'h10; cpu_req3 = 1'b1;         // cycle 0
        step;                                                     // cycle 1
        chk1 ("t5_c1_mem_en",  mem_en3,  1'b1);
        chk32("t5_c1_mem_adr", mem_adr3, 32'h10);
        step;                                                     // cycle 2
        chk1 ("t5_c2_mem_en",  mem_en3,  1'b0);
        chk1 ("t5_c2_busy",    busy3,    1'b1);
        chk1 ("t5_c2_cpu_rdy", cpu_rdy3, 1'b0);
        step;                                                     // cycle 3
        chk1 ("t5_c3_cpu_rdy", cpu_rdy3, 1'b0);
        step; mem_rd3 = 32'h1234_5678;                            // cycle 4
        chk1 ("t5_c4_cpu_rdy", cpu_rdy3, 1'b0);
        step; mem_rd3 = GARBAGE;                                  // cycle 5
        chk1 ("t5_c5_cpu_rdy", cpu_rdy3, 1'b1);
        chk32("t5_c5_cpu_rd",  cpu_rd3,  32'h1234_5678);
        chk32("t5_c5_ld_rd",   ld_rd3,   32'h0);
        cpu_req3 = 1'b0;
        step;
        chk1 ("t5_c6_busy",    busy3,    1'b0);
        chk1 ("t5_c6_cpu_rdy", cpu_rdy3, 1'b0);

        // ---- Reset during WAIT, then pending CPU request wins ------------
        cpu_req3 = 1'b1;                                          // cycle 0
        step;                                                     // ISSUE
        step;                                                     // WAIT
        chk1 ("t6_wait_busy", busy3, 1'b1);
        ld_we = 1'b0; ld_req3 = 1'b1;
        reset = 1'b0;
        #1;
        chk1 ("t6_rst_busy",    busy3,    1'b0);
        chk1 ("t6_rst_mem_en",  mem_en3,  1'b0);
        chk1 ("t6_rst_mem_we",  mem_we3,  1'b0);
        chk32("t6_rst_mem_adr", mem_adr3, 32'h0);
        chk32("t6_rst_mem_wd",  mem_wd3,  32'h0);
        chk1 ("t6_rst_cpu_rdy", cpu_rdy3, 1'b0);
        chk1 ("t6_rst_ld_rdy",  ld_rdy3,  1'b0);
        chk32("t6_rst_cpu_rd",  cpu_rd3,  32'h0);
        step;
        chk1 ("t6_rst_hold_cpu_rdy", cpu_rdy3, 1'b0);
        reset = 1'b1;                                             // cycle 0
        step;                                                     // cycle 1
        chk1 ("t6_regrant_mem_en",  mem_en3,  1'b1);
        chk32("t6_regrant_mem_adr", mem_adr3, 32'h10);
        step;                                                     // cycle 2
        chk1 ("t6_c2_cpu_rdy", cpu_rdy3, 1'b0);
        step;                                                     // cycle 3
        step; mem_rd3 = 32'hCAFE_F00D;                            // cycle 4
        step; mem_rd3 = GARBAGE;                                  // cycle 5
        chk1 ("t6_c5_cpu_rdy", cpu_rdy3, 1'b1);
        chk1 ("t6_c5_ld_rdy",  ld_rdy3,  1'b0);
        chk32("t6_c5_cpu_rd",  cpu_rd3,  32'hCAFE_F00D);
        cpu_req3 = 1'b0; ld_req3 = 1'b0;
        step;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
